// File: rtl/decompress_block.sv
// Dequantizes one 8x8 coefficient block and runs a row-then-column fixed-point IDCT.
// Latency 16 edges accept->block_done; start_block is ignored while busy (no queueing).
module decompress_block #(
  parameter int BLOCK_SIZE  = 8,
  parameter int COEFF_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_block,
  input  logic signed [COEFF_WIDTH-1:0] quantized_coeffs [BLOCK_SIZE][BLOCK_SIZE],
  input  logic        [7:0]             quant_table      [BLOCK_SIZE][BLOCK_SIZE],
  output logic signed [8:0]             pixel_block      [BLOCK_SIZE][BLOCK_SIZE],
  output logic                          busy,
  output logic                          block_done
);
  localparam int N  = BLOCK_SIZE;
  localparam int FW = COEFF_WIDTH + 9;
  localparam int TW = COEFF_WIDTH + 21;
  localparam int AW = COEFF_WIDTH + 33;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROW  = 2'd1;
  localparam logic [1:0] S_COL  = 2'd2;

  // C[k][n] = round(256 * c(k) * cos((2n+1)k*pi/16)), signed Q1.8
  localparam logic signed [8:0] C_ROM [8][8] = '{
    '{ 9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91  },
    '{ 9'sd126,  9'sd106,  9'sd71,   9'sd25,  -9'sd25,  -9'sd71,  -9'sd106, -9'sd126 },
    '{ 9'sd118,  9'sd49,  -9'sd49,  -9'sd118, -9'sd118, -9'sd49,   9'sd49,   9'sd118 },
    '{ 9'sd106, -9'sd25,  -9'sd126, -9'sd71,   9'sd71,   9'sd126,  9'sd25,  -9'sd106 },
    '{ 9'sd91,  -9'sd91,  -9'sd91,   9'sd91,   9'sd91,  -9'sd91,  -9'sd91,   9'sd91  },
    '{ 9'sd71,  -9'sd126,  9'sd25,   9'sd106, -9'sd106, -9'sd25,   9'sd126, -9'sd71  },
    '{ 9'sd49,  -9'sd118,  9'sd118, -9'sd49,  -9'sd49,   9'sd118, -9'sd118,  9'sd49  },
    '{ 9'sd25,  -9'sd71,   9'sd106, -9'sd126,  9'sd126, -9'sd106,  9'sd71,  -9'sd25  }
  };

  logic        [1:0]    r_state;
  logic        [2:0]    r_idx;
  logic signed [FW-1:0] r_coef [N][N];
  logic signed [TW-1:0] r_t    [N][N];

  logic signed [FW-1:0] w_deq [N][N];
  logic        [7:0]    w_q;
  logic signed [TW-1:0] w_row [N];
  logic signed [AW-1:0] w_acc [N];
  logic signed [AW-1:0] w_y;
  logic signed [8:0]    w_sat [N];

  always_comb begin
    w_q = 8'd1;
    for (int u = 0; u < N; u++) begin
      for (int v = 0; v < N; v++) begin
        w_q = (quant_table[u][v] == 8'd0) ? 8'd1 : quant_table[u][v];
        w_deq[u][v] = FW'(quantized_coeffs[u][v]) * FW'($signed({1'b0, w_q}));
      end
    end
  end

  always_comb begin
    for (int n = 0; n < N; n++) begin
      w_row[n] = '0;
      for (int v = 0; v < N; v++)
        w_row[n] = w_row[n] + TW'(r_coef[r_idx][v]) * TW'(C_ROM[v][n]);
    end
  end

  // Column result rounds half up at bit 16, then clips to the Q9.0 range.
  always_comb begin
    w_y = '0;
    for (int m = 0; m < N; m++) begin
      w_acc[m] = '0;
      for (int u = 0; u < N; u++)
        w_acc[m] = w_acc[m] + AW'(C_ROM[u][m]) * AW'(r_t[u][r_idx]);
      w_y = (w_acc[m] + AW'(32'sd32768)) >>> 16;
      if (w_y > AW'(32'sd255))
        w_sat[m] = 9'sd255;
      else if (w_y < AW'(-32'sd256))
        w_sat[m] = -9'sd256;
      else
        w_sat[m] = w_y[8:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      busy       <= 1'b0;
      block_done <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_coef[i][j]      <= '0;
          r_t[i][j]         <= '0;
          pixel_block[i][j] <= '0;
        end
      end
    end else begin
      block_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_block) begin
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++)
                r_coef[i][j] <= w_deq[i][j];
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= S_ROW;
          end
        end
        S_ROW: begin
          for (int n = 0; n < N; n++)
            r_t[r_idx][n] <= w_row[n];
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7)
            r_state <= S_COL;
        end
        S_COL: begin
          for (int m = 0; m < N; m++)
            pixel_block[m][r_idx] <= w_sat[m];
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            block_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decompress_block.sv
// Scoreboard bench for decompress_block: expected blocks are queued at stimulus time
// and popped when block_done pulses.
module tb_decompress_block;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               start_block;
  logic signed [15:0] qc [8][8];
  logic        [7:0]  qt [8][8];
  logic signed [8:0]  pixel_block [8][8];
  logic               busy;
  logic               block_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int cr [8][8];
  int orig [8][8];
  logic [575:0] exp_q [$];

  decompress_block #(.BLOCK_SIZE(8), .COEFF_WIDTH(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_block      (start_block),
    .quantized_coeffs (qc),
    .quant_table      (qt),
    .pixel_block      (pixel_block),
    .busy             (busy),
    .block_done       (block_done)
  );

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi($floor(r + 0.5));
    return -$rtoi($floor(-r + 0.5));
  endfunction

  function automatic real ck(input int k);
    return (k == 0) ? $sqrt(0.125) : 0.5;
  endfunction

  function automatic void init_rom();
    real pi;
    pi = 3.14159265358979323846;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++)
        cr[k][n] = rnd(256.0 * ck(k) * $cos(real'((2 * n + 1) * k) * pi / 16.0));
  endfunction

  function automatic logic [575:0] pack_pixels();
    logic [575:0] r;
    r = '0;
    for (int m = 0; m < 8; m++)
      for (int n = 0; n < 8; n++)
        r[(m * 8 + n) * 9 +: 9] = pixel_block[m][n];
    return r;
  endfunction

  function automatic logic [575:0] const_block(input int val);
    logic [575:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[i * 9 +: 9] = 9'(val);
    return r;
  endfunction

  // Bit-level reference of dequant + row pass + column pass on 64-bit integers.
  function automatic logic [575:0] model_block();
    longint f [8][8];
    longint t [8][8];
    longint a, y;
    int qv;
    logic [575:0] r;
    r = '0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        qv = (qt[u][v] == 8'd0) ? 1 : int'(qt[u][v]);
        f[u][v] = longint'(qc[u][v]) * longint'(qv);
      end
    for (int u = 0; u < 8; u++)
      for (int n = 0; n < 8; n++) begin
        t[u][n] = 0;
        for (int v = 0; v < 8; v++) t[u][n] += f[u][v] * longint'(cr[v][n]);
      end
    for (int m = 0; m < 8; m++)
      for (int n = 0; n < 8; n++) begin
        a = 0;
        for (int u = 0; u < 8; u++) a += longint'(cr[u][m]) * t[u][n];
        y = (a + 64'sd32768) >>> 16;
        if (y > 255) y = 255;
        if (y < -256) y = -256;
        r[(m * 8 + n) * 9 +: 9] = 9'(y);
      end
    return r;
  endfunction

  task automatic set_block(input int dc, input int qdc, input int qrest);
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        qc[u][v] = '0;
        qt[u][v] = 8'(qrest);
      end
    qc[0][0] = 16'(dc);
    qt[0][0] = 8'(qdc);
  endtask

  // Pulses start for one edge, then measures latency and busy cycles (bounded wait).
  task automatic do_block(output int lat, output int busy_cyc, output logic [575:0] pix, output bit ok);
    @(negedge clk);
    start_block = 1'b1;
    @(posedge clk);
    #1;
    start_block = 1'b0;
    busy_cyc = busy ? 1 : 0;
    lat = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (block_done) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
    end
    pix = pack_pixels();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_block = 1'b0;
    set_block(0, 1, 1);
    #12;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++;
    if (block_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", block_done); end
    tests_run++;
    if (pack_pixels() !== '0) begin tests_failed++; $display("FAIL reset_pixels got %h want 0", pack_pixels()); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int lat, bc; logic [575:0] pix, exp_v; bit ok;
    set_block(0, 1, 1);
    exp_q.push_back(const_block(0));
    do_block(lat, bc, pix, ok);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL zero_timeout no block_done within 40 cycles"); end
    tests_run++;
    if (lat != 16) begin tests_failed++; $display("FAIL zero_latency got %0d want 16", lat); end
    tests_run++;
    if (bc != 16) begin tests_failed++; $display("FAIL zero_busy_cycles got %0d want 16", bc); end
    tests_run++;
    if (pix !== exp_v) begin tests_failed++; $display("FAIL zero_pixels got %h want %h", pix, exp_v); end
    @(posedge clk);
    #1;
    tests_run++;
    if (block_done !== 1'b0) begin tests_failed++; $display("FAIL done_pulse_width got %b want 0", block_done); end
  endtask

  task automatic test_dc();
    int lat, bc; logic [575:0] pix, exp_v; bit ok;
    set_block(2, 32, 1);
    exp_q.push_back(const_block(8));
    do_block(lat, bc, pix, ok);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (!ok || lat != 16) begin tests_failed++; $display("FAIL dc_latency got %0d want 16", lat); end
    tests_run++;
    if (pix !== exp_v) begin tests_failed++; $display("FAIL dc_pixels got %h want %h", pix, exp_v); end
  endtask

  task automatic test_saturation();
    int lat, bc; logic [575:0] pix, exp_v; bit ok;
    set_block(4000, 1, 1);
    exp_q.push_back(const_block(255));
    do_block(lat, bc, pix, ok);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (!ok || pix !== exp_v) begin tests_failed++; $display("FAIL sat_pos got %h want %h", pix, exp_v); end
    set_block(-4000, 1, 1);
    exp_q.push_back(const_block(-256));
    do_block(lat, bc, pix, ok);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (!ok || pix !== exp_v) begin tests_failed++; $display("FAIL sat_neg got %h want %h", pix, exp_v); end
  endtask

  task automatic test_round_trip();
    int lat, bc, err, max_err; logic [575:0] pix, exp_v; bit ok;
    logic signed [8:0] p;
    real s, pi;
    pi = 3.14159265358979323846;
    for (int m = 0; m < 8; m++)
      for (int n = 0; n < 8; n++) orig[m][n] = int'($urandom_range(0, 40)) - 20;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        s = 0.0;
        for (int m = 0; m < 8; m++)
          for (int n = 0; n < 8; n++)
            s += ck(u) * ck(v) * $cos(real'((2 * m + 1) * u) * pi / 16.0)
                 * $cos(real'((2 * n + 1) * v) * pi / 16.0) * real'(orig[m][n]);
        qc[u][v] = 16'(rnd(s));
      end
    for (int pass = 0; pass < 2; pass++) begin
      for (int u = 0; u < 8; u++)
        for (int v = 0; v < 8; v++) qt[u][v] = (pass == 0) ? 8'd1 : 8'd0;
      exp_q.push_back(model_block());
      do_block(lat, bc, pix, ok);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (!ok || pix !== exp_v) begin tests_failed++; $display("FAIL roundtrip_exact_q%0d got %h want %h", 1 - pass, pix, exp_v); end
      max_err = 0;
      for (int i = 0; i < 64; i++) begin
        p = pix[i * 9 +: 9];
        err = int'(p) - orig[i / 8][i % 8];
        if (err < 0) err = -err;
        if (err > max_err) max_err = err;
      end
      tests_run++;
      if (max_err > 1) begin tests_failed++; $display("FAIL roundtrip_err_q%0d got max %0d want <=1", 1 - pass, max_err); end
    end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int dn [$];
    logic prev_busy;
    logic [575:0] pix, exp_v;
    set_block(2, 32, 1);
    exp_q.push_back(model_block());
    prev_busy = 1'b0;
    @(negedge clk);
    start_block = 1'b1;
    for (int e = 0; e <= 50; e++) begin
      @(posedge clk);
      #1;
      if (busy && !prev_busy) acc.push_back(e);
      prev_busy = busy;
      if (block_done) begin
        dn.push_back(e);
        pix = pack_pixels();
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL b2b_extra_done at edge %0d", e);
        end else begin
          exp_v = exp_q.pop_front();
          if (pix !== exp_v) begin tests_failed++; $display("FAIL b2b_pixels edge %0d got %h want %h", e, pix, exp_v); end
        end
      end
      if (e == 0) begin
        set_block(4000, 1, 1);
        exp_q.push_back(model_block());
      end
      if (e == 17) begin
        set_block(0, 1, 1);
        for (int u = 0; u < 4; u++)
          for (int v = 0; v < 4; v++) qc[u][v] = 16'($urandom_range(0, 200)) - 16'd100;
        qt[1][1] = 8'd3;
        exp_q.push_back(model_block());
      end
    end
    start_block = 1'b0;
    tests_run++;
    if (acc.size() != 3 || dn.size() != 3) begin
      tests_failed++; $display("FAIL b2b_counts got accepts %0d dones %0d want 3 3", acc.size(), dn.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (acc[i] != 17 * i || dn[i] != 17 * i + 16) begin
          tests_failed++; $display("FAIL b2b_timing block %0d got accept %0d done %0d want %0d %0d", i, acc[i], dn[i], 17 * i, 17 * i + 16);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_block();
    int lat, bc, spurious; logic [575:0] pix, exp_v; bit ok;
    repeat (3) @(posedge clk);
    set_block(-2, 32, 1);
    @(negedge clk);
    start_block = 1'b1;
    @(posedge clk);
    #1;
    start_block = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || block_done !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_ctrl got busy %b done %b want 0 0", busy, block_done);
    end
    tests_run++;
    if (pack_pixels() !== '0) begin tests_failed++; $display("FAIL midreset_pixels got %h want 0", pack_pixels()); end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (block_done || busy) spurious++;
    end
    tests_run++;
    if (spurious != 0) begin tests_failed++; $display("FAIL midreset_spurious got %0d active cycles want 0", spurious); end
    set_block(2, 32, 1);
    exp_q.push_back(const_block(8));
    do_block(lat, bc, pix, ok);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (!ok || lat != 16) begin tests_failed++; $display("FAIL midreset_latency got %0d want 16", lat); end
    tests_run++;
    if (pix !== exp_v) begin tests_failed++; $display("FAIL midreset_pixels_after got %h want %h", pix, exp_v); end
  endtask

  initial begin
    init_rom();
    test_reset();
    test_zero();
    test_dc();
    test_saturation();
    test_round_trip();
    test_back_to_back();
    test_reset_mid_block();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
